data_memory_mc: RTL and testbench

Parametrised, clocked data memory for the multi-cycle datapath. It replaces the combinational-write array with a req/ready/done handshake, per-byte write enables, programmable access latency, out-of-range detection and a hardware fill sequence. The fill runs after reset and writes each word with its own index, or with zero. It sits between the multi-cycle control unit and the memory-stage registers.

---
 rtl/data_memory_pkg.sv | 21 ++
 rtl/data_mem_array.sv | 34 +++
 rtl/data_memory_mc.sv | 167 ++++++++++++++++
 tb/tb_data_memory_mc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and sizing helpers for the multi-cycle data memory
package data_memory_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 256;
    localparam int NBYTES     = DEF_DATA_W / 8;
    localparam int CNT_W      = $clog2(DEF_DEPTH);

    // Index width for a given word count; never narrower than one bit
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with one byte-enabled sync write port and one async read port
module data_mem_array
    import data_memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NB     = NBYTES,
    parameter int AW     = CNT_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NB-1:0]     be,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-granular write; lanes with a clear enable keep their old contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) begin
                    mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_mc.sv
// rtl/data_memory_mc.sv - handshaked data memory with fill sequence, programmable latency and range check
module data_memory_mc
    import data_memory_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                init_busy
);

    localparam int NB = DATA_W / 8;
    localparam int CW = cnt_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(DEPTH - 1);

    state_t            state;
    logic [CW-1:0]     fill_cnt;
    logic [2:0]        wait_cnt;
    logic              we_q;
    logic [CW-1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic              in_range_q;

    logic              in_range_in;
    logic              cur_in_range;
    logic              cur_read;
    logic [CW-1:0]     mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_we;
    logic [CW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] fill_word;

    assign in_range_in = ({1'b0, addr} < DEPTH_A);

    // Response source: live inputs when accepting straight into RESP, latched copy otherwise
    always_comb begin
        cur_in_range = in_range_q;
        cur_read     = !we_q;
        mem_raddr    = addr_q;
        if (state == IDLE) begin
            cur_in_range = in_range_in;
            cur_read     = !we;
            mem_raddr    = addr[CW-1:0];
        end
        resp_rdata = (cur_in_range && cur_read) ? mem_rdata : '0;
    end

    assign fill_word = (INIT_INDEX != 0) ? DATA_W'(fill_cnt) : '0;

    // Write port shared by the fill sequence and committed accesses; reset blocks any write
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
        if (state == INIT) begin
            mem_we    = !reset;
            mem_waddr = fill_cnt;
            mem_wdata = fill_word;
            mem_be    = '1;
        end else if (state == RESP) begin
            mem_we = !reset && we_q && in_range_q;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NB     (NB),
        .AW     (CW)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .be     (mem_be),
        .raddr  (mem_raddr),
        .rdata  (mem_rdata)
    );

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            fill_cnt   <= '0;
            wait_cnt   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            in_range_q <= 1'b0;
            ready      <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            init_busy  <= 1'b1;
        end else begin
            done  <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
            case (state)
                INIT: begin
                    if (fill_cnt == LAST_IDX) begin
                        state     <= IDLE;
                        ready     <= 1'b1;
                        init_busy <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (req) begin
                        we_q       <= we;
                        addr_q     <= addr[CW-1:0];
                        wdata_q    <= wdata;
                        be_q       <= be;
                        in_range_q <= in_range_in;
                        ready      <= 1'b0;
                        if (LATENCY > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 3'(LATENCY);
                        end else begin
                            state <= RESP;
                            done  <= 1'b1;
                            rdata <= resp_rdata;
                            err   <= !in_range_in;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        state <= RESP;
                        done  <= 1'b1;
                        rdata <= resp_rdata;
                        err   <= !in_range_q;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_mc.sv
// tb/tb_data_memory_mc.sv - scoreboard bench for data_memory_mc across three configurations
module tb_data_memory_mc;

    localparam int N = 3;
    localparam int LAT_P [N] = '{1, 3, 0};
    localparam int IDX_P [N] = '{1, 0, 1};
    localparam int DEP_P [N] = '{256, 64, 64};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [N];
    logic        req   [N];
    logic        we    [N];
    logic [15:0] addr  [N];
    logic [31:0] wdata [N];
    logic [3:0]  be    [N];
    logic        ready [N];
    logic        done  [N];
    logic [31:0] rdata [N];
    logic        err   [N];
    logic        busy  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_memory_mc #(
            .DATA_W     (32),
            .ADDR_W     (16),
            .DEPTH      (DEP_P[g]),
            .LATENCY    (LAT_P[g]),
            .INIT_INDEX (IDX_P[g])
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req       (req[g]),
            .we        (we[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .be        (be[g]),
            .ready     (ready[g]),
            .done      (done[g]),
            .rdata     (rdata[g]),
            .err       (err[g]),
            .init_busy (busy[g])
        );
    end

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [N][$];
    logic [31:0] model [N][256];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (done[g] === 1'b1) begin
                if (sb[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done[%0d]: got done=1, expected 0 (cycle %0d)", g, cyc);
                end else begin
                    mon_e = sb[g].pop_front();
                    check($sformatf("done_cycle[%0d]", g), cyc, mon_e.cyc);
                    check($sformatf("rdata[%0d]", g), rdata[g], mon_e.rdata);
                    check($sformatf("err[%0d]", g), {31'd0, err[g]}, {31'd0, mon_e.err});
                end
            end
        end
    end

    task automatic fill_model(input int g);
        for (int i = 0; i < 256; i++) model[g][i] = (IDX_P[g] != 0 && i < DEP_P[g]) ? i : 0;
    endtask

    // Reference behaviour: expected response and memory effect of an access accepted at cycle t
    task automatic predict(input int g, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] b, input int t);
        exp_t e;
        e.cyc   = t + 1 + LAT_P[g];
        e.rdata = 32'd0;
        e.err   = 1'b0;
        if (int'(a) >= DEP_P[g]) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) model[g][a][8*k +: 8] = d[8*k +: 8];
        end else begin
            e.rdata = model[g][a];
        end
        sb[g].push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge where ready is seen high
    task automatic wait_ready(input int g, input int max_cycles, output bit ok);
        int n = 0;
        while (ready[g] !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        ok = (ready[g] === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout[%0d]: got ready=%b, expected 1 within %0d cycles", g, ready[g], max_cycles);
        end
    endtask

    task automatic access(input int g, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] b, input bit expect_done);
        bit ok;
        wait_ready(g, 20, ok);
        if (ok) begin
            req[g] = 1'b1; we[g] = w; addr[g] = a; wdata[g] = d; be[g] = b;
            if (expect_done) predict(g, w, a, d, b, cyc);
            @(negedge clk);
            req[g] = 1'b0;
            addr[g] = 16'($urandom);
            we[g]   = 1'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t;
        int g;
        logic [15:0] a;

        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
            fill_model(i);
        end
        repeat (3) @(negedge clk);

        check("reset_ready", {31'd0, ready[0]}, 32'd0);
        check("reset_busy", {31'd0, busy[0]}, 32'd1);
        check("reset_done", {31'd0, done[0]}, 32'd0);
        check("reset_rdata_err", {rdata[0][30:0], err[0]}, 32'd0);

        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        // Fill must hold ready low and init_busy high for exactly DEPTH cycles
        for (int i = 0; i < 256; i++) begin
            req[0] = 1'($urandom);
            check("init_ready_busy", {30'd0, ready[0], busy[0]}, 32'd1);
            @(negedge clk);
        end
        req[0] = 1'b0;
        check("init_end_ready_busy", {30'd0, ready[0], busy[0]}, 32'd2);

        // Directed accesses on the default instance
        access(0, 1'b0, 16'd5,   32'h0, 4'h0, 1'b1);
        access(0, 1'b1, 16'd10,  32'hDEADBEEF, 4'b0011, 1'b1);
        access(0, 1'b0, 16'd10,  32'h0, 4'h0, 1'b1);
        access(0, 1'b1, 16'd10,  32'h12345678, 4'b0000, 1'b1);
        access(0, 1'b0, 16'd10,  32'h0, 4'h0, 1'b1);
        access(0, 1'b1, 16'd300, 32'hCAFEF00D, 4'hF, 1'b1);
        access(0, 1'b0, 16'd300, 32'h0, 4'h0, 1'b1);
        access(0, 1'b0, 16'd44,  32'h0, 4'h0, 1'b1);
        check("model_addr10", model[0][10], 32'h0000BEEF);

        // req held high with changing inputs: only the next legal slot is accepted
        wait_ready(0, 20, ok);
        if (ok) begin
            t = cyc;
            a = 16'($urandom_range(0, 255));
            req[0] = 1'b1; we[0] = 1'b0; addr[0] = a;
            predict(0, 1'b0, a, 32'h0, 4'h0, t);
            for (int k = 1; k <= LAT_P[0] + 1; k++) begin
                @(negedge clk);
                check("held_ready_low", {31'd0, ready[0]}, 32'd0);
                addr[0] = 16'($urandom_range(0, 300));
                we[0] = 1'($urandom); wdata[0] = $urandom; be[0] = 4'($urandom);
            end
            @(negedge clk);
            check("held_next_accept_ready", {31'd0, ready[0]}, 32'd1);
            a = 16'($urandom_range(0, 255));
            we[0] = 1'b0; addr[0] = a;
            predict(0, 1'b0, a, 32'h0, 4'h0, cyc);
            @(negedge clk);
            req[0] = 1'b0;
        end

        // Randomised traffic over all three configurations
        for (int n = 0; n < 60; n++) begin
            g = $urandom_range(0, N - 1);
            access(g, 1'($urandom), 16'($urandom_range(0, DEP_P[g] + 40)),
                   $urandom, 4'($urandom), 1'b1);
        end

        // Reset during WAIT abandons the write and restarts the fill
        wait_ready(0, 20, ok);
        if (ok) begin
            req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'd7; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF;
            @(negedge clk);
            req[0] = 1'b0;
            rst[0] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("midreset_ready_busy", {30'd0, ready[0], busy[0]}, 32'd1);
            rst[0] = 1'b0;
            fill_model(0);
            wait_ready(0, 300, ok);
            access(0, 1'b0, 16'd7, 32'h0, 4'h0, 1'b1);
            check("model_addr7", model[0][7], 32'h00000007);
        end

        // Latency 3 with zero fill, and latency 0
        access(1, 1'b0, 16'd3, 32'h0, 4'h0, 1'b1);
        access(2, 1'b0, 16'd3, 32'h0, 4'h0, 1'b1);
        access(2, 1'b0, 16'd64, 32'h0, 4'h0, 1'b1);

        for (int n = 0; n < 20; n++) @(negedge clk);
        for (int i = 0; i < N; i++) check($sformatf("pending_left[%0d]", i), sb[i].size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
